instruction_queue: RTL and testbench

Decoupling buffer between instruction fetch and decode in the RISC-V pipeline. It captures each fetched {PC, PC+4, instruction} triple when the fetch stage produces one and presents the oldest entry to decode in program order. Fetch can run ahead while decode is stalled by data-memory busywait or hazards. A branch/jump flush discards all buffered entries.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/instruction_queue_storage.sv | 34 +++
 rtl/instruction_queue.sv | 91 +++++++++
 tb/tb_instruction_queue.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ============================================================================
//  pipeline_pkg
//  Shared pipeline constants and the fetch-entry type used by fetch/decode.
//  Rev 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instruction;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/instruction_queue_storage.sv
// ============================================================================
//  instruction_queue_storage
//  DEPTH x fetch_entry_t register array, one sync write port, one async read.
//  Rev 1.0
// ============================================================================
`default_nettype none

module instruction_queue_storage
    import pipeline_pkg::fetch_entry_t;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     write_en,
    input  logic [$clog2(DEPTH)-1:0] write_addr,
    input  fetch_entry_t             write_data,
    input  logic [$clog2(DEPTH)-1:0] read_addr,
    output fetch_entry_t             read_data
);

    fetch_entry_t mem [DEPTH];

    // Contents are deliberately never reset; validity lives in the pointers.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

`default_nettype wire

// File: rtl/instruction_queue.sv
// ============================================================================
//  instruction_queue
//  Fetch-to-decode decoupling FIFO with flush; presents oldest entry to decode.
//  Rev 1.0
// ============================================================================
`default_nettype none

module instruction_queue
    import pipeline_pkg::fetch_entry_t;
    import pipeline_pkg::XLEN;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fetch_valid,
    input  logic [XLEN-1:0]          fetch_pc,
    input  logic [XLEN-1:0]          fetch_pc_plus4,
    input  logic [XLEN-1:0]          fetch_instruction,
    output logic                     fetch_stall,
    input  logic                     flush,
    input  logic                     decode_ready,
    output logic                     id_valid,
    output logic [XLEN-1:0]          id_pc,
    output logic [XLEN-1:0]          id_pc_plus4,
    output logic [XLEN-1:0]          id_instruction,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    // Stall and valid derive only from registered count, so decode_ready
    // never reaches fetch_stall combinationally.
    assign fetch_stall = (count == CNT_W'(DEPTH));
    assign id_valid    = (count != '0);
    assign push        = fetch_valid & ~fetch_stall & ~flush;
    assign pop         = id_valid & decode_ready & ~flush;
    assign occupancy   = count;

    assign wr_entry.pc          = fetch_pc;
    assign wr_entry.pc_plus4    = fetch_pc_plus4;
    assign wr_entry.instruction = fetch_instruction;

    instruction_queue_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clock      (clock),
        .write_en   (push),
        .write_addr (wr_ptr),
        .write_data (wr_entry),
        .read_addr  (rd_ptr),
        .read_data  (head)
    );

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign id_pc          = id_valid ? head.pc          : '0;
    assign id_pc_plus4    = id_valid ? head.pc_plus4    : '0;
    assign id_instruction = id_valid ? head.instruction : NOP_INSTR;

endmodule

`default_nettype wire

// File: tb/tb_instruction_queue.sv
// ============================================================================
//  tb_instruction_queue
//  Directed + random stimulus against a queue-based model of the fetch buffer.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_instruction_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ins;
    } ent_t;

    logic        clock;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_plus4;
    logic [31:0] fetch_instruction;
    logic        fetch_stall;
    logic        flush;
    logic        decode_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instruction;
    logic [2:0]  occupancy;

    int          vectors = 0;
    int          errors  = 0;
    ent_t        model[$];
    logic [31:0] cur_pc;
    logic [31:0] cur_instr;

    instruction_queue #(
        .DEPTH     (DEPTH),
        .NOP_INSTR (32'h00000013)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_pc_plus4    (fetch_pc_plus4),
        .fetch_instruction (fetch_instruction),
        .fetch_stall       (fetch_stall),
        .flush             (flush),
        .decode_ready      (decode_ready),
        .id_valid          (id_valid),
        .id_pc             (id_pc),
        .id_pc_plus4       (id_pc_plus4),
        .id_instruction    (id_instruction),
        .occupancy         (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic v;
        v = (model.size() != 0);
        chk("id_valid",       {31'd0, id_valid},    {31'd0, v});
        chk("id_pc",          id_pc,                v ? model[0].pc  : 32'd0);
        chk("id_pc_plus4",    id_pc_plus4,          v ? model[0].pc4 : 32'd0);
        chk("id_instruction", id_instruction,       v ? model[0].ins : 32'h00000013);
        chk("fetch_stall",    {31'd0, fetch_stall}, {31'd0, model.size() == DEPTH});
        chk("occupancy",      {29'd0, occupancy},   32'(model.size()));
    endtask

    // One clock cycle: check current outputs, apply inputs, advance the model.
    task automatic cycle(input logic fv, input logic fl, input logic dr, input logic rs);
        logic do_push, do_pop;
        ent_t e;
        check_outputs();
        fetch_valid       = fv;
        flush             = fl;
        decode_ready      = dr;
        reset             = rs;
        fetch_pc          = cur_pc;
        fetch_pc_plus4    = cur_pc + 32'd4;
        fetch_instruction = cur_instr;
        do_push = fv && (model.size() != DEPTH) && !fl;
        do_pop  = (model.size() != 0) && dr && !fl;
        e = '{cur_pc, cur_pc + 32'd4, cur_instr};
        @(posedge clock);
        #1;
        if (rs || fl) begin
            model.delete();
        end else begin
            if (do_pop)  void'(model.pop_front());
            if (do_push) model.push_back(e);
        end
        if (do_push && !rs) begin
            cur_pc    = cur_pc + 32'd4;
            cur_instr = $urandom;
        end
    endtask

    initial begin
        fetch_valid = 0; flush = 0; decode_ready = 0; reset = 1;
        fetch_pc = 0; fetch_pc_plus4 = 0; fetch_instruction = 0;
        cur_pc = 0; cur_instr = $urandom;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 0;

        // Reset / idle
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        chk("idle_nop", id_instruction, 32'h00000013);
        chk("idle_occ", {29'd0, occupancy}, 32'd0);

        // Fill to full, fifth push ignored, then drain in order
        cur_pc = 32'h0;
        repeat (4) cycle(1, 0, 0, 0);
        chk("full_occ",   {29'd0, occupancy}, 32'd4);
        chk("full_stall", {31'd0, fetch_stall}, 32'd1);
        cycle(1, 0, 0, 0);
        chk("fifth_ignored_pc", cur_pc, 32'h10);
        chk("head_after_full", id_pc, 32'h0);
        repeat (5) cycle(0, 0, 1, 0);

        // Continuous push/pop across pointer wrap
        cur_pc = 32'h100;
        cycle(1, 0, 0, 0);
        repeat (10) cycle(1, 0, 1, 0);
        chk("stream_occ", {29'd0, occupancy}, 32'd1);
        chk("stream_head", id_pc, 32'h128);
        cycle(0, 0, 1, 0);

        // Flush with simultaneous fetch; push after flush appears at head
        cur_pc = 32'h200;
        repeat (3) cycle(1, 0, 0, 0);
        cur_pc = 32'h40;
        cycle(1, 1, 0, 0);
        chk("flush_occ",   {29'd0, occupancy}, 32'd0);
        chk("flush_valid", {31'd0, id_valid},  32'd0);
        cur_pc = 32'h80;
        cycle(1, 0, 0, 0);
        chk("post_flush_head", id_pc, 32'h80);
        repeat (2) cycle(0, 0, 1, 0);

        // Full queue, pop with fetch held: held entry accepted exactly once
        cur_pc = 32'h300;
        repeat (5) cycle(1, 0, 0, 0);
        repeat (6) cycle(1, 0, 1, 0);
        repeat (3) cycle(0, 0, 1, 0);

        // Reset mid-operation at occupancy 2 with push/pop active
        cur_pc = 32'h400;
        repeat (2) cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 1);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instruction, 32'h00000013);
        chk("rst_pc",    id_pc, 32'd0);
        chk("rst_occ",   {29'd0, occupancy}, 32'd0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            logic fv, dr, fl, rs;
            fv = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 63) == 0);
            cycle(fv, fl, dr, rs);
            if (fl || rs) cur_pc = $urandom & 32'hFFFF_FFFC;
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
